// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter sharing one SPI CSB/SDI/LDB link among NUM_REQ frame requesters.
// A granted frame is shifted out MSB-first under CSB, then strobed into the slave with LDB.
module spi_frame_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FRAME_W    = 60,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                       SPI_CLK,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic                       SPI_CSB,
    output logic                       SPI_SDI,
    output logic                       SPI_LDB
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(FRAME_W + 1);
    localparam int unsigned GAP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD,
        ST_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 csb_q, csb_d;
    logic                 sdi_q, sdi_d;
    logic                 ldb_q, ldb_d;

    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     cand_idx;
    logic [FRAME_W-1:0]   win_frame;

    // Round-robin search starting one past the last winner.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand_idx = PTR_W'((32'(ptr_q) + off) % NUM_REQ);
            if (!win_vld && req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
        win_frame = req_data[win_idx*FRAME_W +: FRAME_W];
    end

    // Outputs are computed for the next state so that every pin comes straight from a flop.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        done_d  = '0;
        csb_d   = 1'b1;
        sdi_d   = 1'b0;
        ldb_d   = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_SHIFT;
                    shreg_d = win_frame;
                    cnt_d   = '0;
                    ptr_d   = win_idx;
                    owner_d = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    csb_d   = 1'b0;
                    sdi_d   = win_frame[FRAME_W-1];
                end
            end
            ST_SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                    state_d = ST_LOAD;
                    ldb_d   = 1'b0;
                    done_d  = NUM_REQ'(1) << owner_q;
                end else begin
                    csb_d = 1'b0;
                    sdi_d = shreg_q[FRAME_W-2];
                end
            end
            ST_LOAD: begin
                gap_d   = '0;
                state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge SPI_CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            csb_q   <= 1'b1;
            sdi_q   <= 1'b0;
            ldb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            csb_q   <= csb_d;
            sdi_q   <= sdi_d;
            ldb_q   <= ldb_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign SPI_CSB = csb_q;
    assign SPI_SDI = sdi_q;
    assign SPI_LDB = ldb_q;

endmodule
